// File: rtl/if_prefetch.sv
// Instruction-fetch front end: runs a fetch PC, keeps one read in flight on the
// instruction bus and buffers {pc, inst, fault} in a small prefetch queue for decode.
// A trap or jump/branch redirect flushes the queue and discards any stale response.
module if_prefetch #(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned INST_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trap_en_i,
    input  logic [ADDR_W-1:0] csr_pc_i,
    input  logic              jb_en_i,
    input  logic [ADDR_W-1:0] jb_addr_i,
    input  logic              stall_fetch_i,
    output logic              bus_valid_o,
    input  logic              bus_ready_i,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [1:0]        bus_size_o,
    output logic              bus_req_o,
    input  logic              bus_rvalid_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic [1:0]        bus_resp_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] out_pc_o,
    output logic [INST_W-1:0] out_inst_o,
    output logic              out_fault_o,
    output logic              flush_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDrop
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    // Set when a redirect lands while a request is still waiting for acceptance.
    logic              kill_q, kill_d;

    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic              push;
    logic              pop;
    logic [31:0]       rsp_word;

    // Prefetch queue storage and bookkeeping
    logic [ADDR_W-1:0] pc_mem    [FIFO_DEPTH];
    logic [INST_W-1:0] inst_mem  [FIFO_DEPTH];
    logic              fault_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    assign redirect   = trap_en_i | jb_en_i;
    assign target     = trap_en_i ? csr_pc_i : jb_addr_i;
    assign flush_o    = redirect;
    assign bus_addr_o = req_addr_q;
    assign bus_size_o = 2'b10;
    assign bus_req_o  = 1'b0;

    // Pick the addressed instruction out of the returned bus word
    if (DATA_W == 64) begin : g_sel64
        assign rsp_word = req_addr_q[2] ? bus_rdata_i[63:32] : bus_rdata_i[31:0];
    end else begin : g_sel32
        assign rsp_word = bus_rdata_i[31:0];
    end

    // Fetch FSM state, PC and request address registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            kill_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            kill_q     <= kill_d;
        end
    end

    // Next-state logic, bus request and queue push decision
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_addr_d  = req_addr_q;
        kill_d      = kill_q;
        push        = 1'b0;
        bus_valid_o = 1'b0;

        if (redirect) begin
            fetch_pc_d = target;
        end

        unique case (state_q)
            StIdle: begin
                // Hold off one cycle on redirect so the request picks up the new target
                if (!redirect && !stall_fetch_i && (count_q < CNT_W'(FIFO_DEPTH))) begin
                    req_addr_d = fetch_pc_q;
                    state_d    = StReq;
                end
            end
            StReq: begin
                bus_valid_o = 1'b1;
                if (redirect) begin
                    kill_d = 1'b1;
                end
                if (bus_ready_i) begin
                    kill_d = 1'b0;
                    if (redirect || kill_q) begin
                        state_d = StDrop;
                    end else begin
                        state_d    = StWait;
                        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                    end
                end
            end
            StWait: begin
                if (bus_rvalid_i) begin
                    state_d = StIdle;
                    push    = !redirect;
                end else if (redirect) begin
                    state_d = StDrop;
                end
            end
            StDrop: begin
                if (bus_rvalid_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign out_valid_o = (count_q != '0);
    assign pop         = out_valid_o & out_ready_i;
    assign out_pc_o    = pc_mem[rd_ptr_q];
    assign out_inst_o  = inst_mem[rd_ptr_q];
    assign out_fault_o = fault_mem[rd_ptr_q];

    // Queue pointers and occupancy; a flush overrides any same-cycle pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (redirect) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Queue payload write (push never coincides with a redirect)
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= req_addr_q;
            inst_mem[wr_ptr_q]  <= INST_W'(rsp_word);
            fault_mem[wr_ptr_q] <= |bus_resp_i;
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: a latency-programmable bus responder plus logs of
// bus handshakes and decode pops, checked against hand-computed pcs and instructions.
module tb_if_prefetch;

    logic        clk;
    logic        rst;
    logic        trap_en_i;
    logic [63:0] csr_pc_i;
    logic        jb_en_i;
    logic [63:0] jb_addr_i;
    logic        stall_fetch_i;
    logic        bus_valid_o;
    logic        bus_ready_i;
    logic [63:0] bus_addr_o;
    logic [1:0]  bus_size_o;
    logic        bus_req_o;
    logic        bus_rvalid_i;
    logic [63:0] bus_rdata_i;
    logic [1:0]  bus_resp_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] out_pc_o;
    logic [31:0] out_inst_o;
    logic        out_fault_o;
    logic        flush_o;

    int checks   = 0;
    int failures = 0;

    // Responder state
    int          lat        = 1;
    int          cnt        = 0;
    logic        pend       = 1'b0;
    logic [63:0] paddr      = '0;
    logic [63:0] fault_addr = 64'h1;

    // Observation logs
    logic [63:0] hs_q[$];
    logic [63:0] pop_pc[$];
    logic [31:0] pop_inst[$];
    logic        pop_fault[$];

    logic [63:0] held_addr;
    int          hs_base;

    if_prefetch dut (
        .clk          (clk),
        .rst          (rst),
        .trap_en_i    (trap_en_i),
        .csr_pc_i     (csr_pc_i),
        .jb_en_i      (jb_en_i),
        .jb_addr_i    (jb_addr_i),
        .stall_fetch_i(stall_fetch_i),
        .bus_valid_o  (bus_valid_o),
        .bus_ready_i  (bus_ready_i),
        .bus_addr_o   (bus_addr_o),
        .bus_size_o   (bus_size_o),
        .bus_req_o    (bus_req_o),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i),
        .bus_resp_i   (bus_resp_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_pc_o     (out_pc_o),
        .out_inst_o   (out_inst_o),
        .out_fault_o  (out_fault_o),
        .flush_o      (flush_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_5A5A;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        hs_q.delete();
        pop_pc.delete();
        pop_inst.delete();
        pop_fault.delete();
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        repeat (2) step();
        clear_logs();
        rst = 1'b1;
    endtask

    task automatic wait_pops(input int n, input string tag);
        for (int i = 0; i < 200 && pop_pc.size() < n; i++) step();
        check(tag, 64'(pop_pc.size() >= n), 64'd1);
    endtask

    // Bus responder and monitors, all on the falling edge away from DUT updates
    always @(negedge clk) begin
        if (!rst) begin
            bus_rvalid_i = 1'b0;
            pend         = 1'b0;
        end else begin
            bus_rvalid_i = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    pend         = 1'b0;
                    bus_rvalid_i = 1'b1;
                    bus_rdata_i  = {inst_of({paddr[63:3], 3'b100}),
                                    inst_of({paddr[63:3], 3'b000})};
                    bus_resp_i   = (paddr == fault_addr) ? 2'b10 : 2'b00;
                end
            end
            if (out_valid_o && out_ready_i) begin
                pop_pc.push_back(out_pc_o);
                pop_inst.push_back(out_inst_o);
                pop_fault.push_back(out_fault_o);
            end
            if (bus_valid_o && bus_ready_i) begin
                hs_q.push_back(bus_addr_o);
                paddr = bus_addr_o;
                pend  = 1'b1;
                cnt   = lat;
            end
        end
    end

    initial begin
        rst           = 1'b0;
        trap_en_i     = 1'b0;
        csr_pc_i      = '0;
        jb_en_i       = 1'b0;
        jb_addr_i     = '0;
        stall_fetch_i = 1'b0;
        bus_ready_i   = 1'b1;
        bus_rvalid_i  = 1'b0;
        bus_rdata_i   = '0;
        bus_resp_i    = 2'b00;
        out_ready_i   = 1'b1;
        #1;
        check("rst_bus_valid", 64'(bus_valid_o), 64'd0);
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_flush", 64'(flush_o), 64'd0);
        check("bus_size", 64'(bus_size_o), 64'd2);
        check("bus_req", 64'(bus_req_o), 64'd0);

        // 1: sequential fetch, both halves of the 64-bit word
        apply_reset();
        wait_pops(3, "t1_timeout");
        check("t1_pc0", pop_pc[0], 64'h8000_0000);
        check("t1_pc1", pop_pc[1], 64'h8000_0004);
        check("t1_pc2", pop_pc[2], 64'h8000_0008);
        check("t1_inst0", 64'(pop_inst[0]), 64'hDA5A_5A5A);
        check("t1_inst1", 64'(pop_inst[1]), 64'hDA5A_5A5E);
        check("t1_inst2", 64'(pop_inst[2]), 64'(inst_of(64'h8000_0008)));

        // 2: decode stalled -> queue fills to depth, then one pop buys one request
        out_ready_i = 1'b0;
        apply_reset();
        repeat (30) step();
        check("t2_hs_count", 64'(hs_q.size()), 64'd4);
        check("t2_bus_idle", 64'(bus_valid_o), 64'd0);
        check("t2_head_pc", out_pc_o, 64'h8000_0000);
        check("t2_head_inst", 64'(out_inst_o), 64'hDA5A_5A5A);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        repeat (20) step();
        check("t2_hs_count2", 64'(hs_q.size()), 64'd5);
        check("t2_hs_addr", hs_q[4], 64'h8000_0010);
        check("t2_bus_idle2", 64'(bus_valid_o), 64'd0);
        check("t2_head_pc2", out_pc_o, 64'h8000_0004);

        // 3: jump during WAIT with a slow response
        lat         = 3;
        out_ready_i = 1'b1;
        hs_base     = hs_q.size();
        for (int i = 0; i < 50 && hs_q.size() == hs_base; i++) step();
        check("t3_req_seen", 64'(hs_q.size() > hs_base), 64'd1);
        jb_en_i   = 1'b1;
        jb_addr_i = 64'h8000_0100;
        #1;
        check("t3_flush", 64'(flush_o), 64'd1);
        step();
        jb_en_i = 1'b0;
        #1;
        clear_logs();
        check("t3_flush_end", 64'(flush_o), 64'd0);
        check("t3_emptied", 64'(out_valid_o), 64'd0);
        wait_pops(1, "t3_timeout");
        check("t3_pc", pop_pc[0], 64'h8000_0100);
        check("t3_inst", 64'(pop_inst[0]), 64'hDA5A_5B5A);

        // 4: trap and jump together while a request waits for acceptance
        lat         = 1;
        bus_ready_i = 1'b0;
        for (int i = 0; i < 30 && !bus_valid_o; i++) step();
        check("t4_req_pending", 64'(bus_valid_o), 64'd1);
        held_addr = bus_addr_o;
        trap_en_i = 1'b1;
        jb_en_i   = 1'b1;
        csr_pc_i  = 64'h8000_0200;
        jb_addr_i = 64'h8000_0300;
        #1;
        check("t4_flush", 64'(flush_o), 64'd1);
        step();
        trap_en_i = 1'b0;
        jb_en_i   = 1'b0;
        clear_logs();
        check("t4_valid_held", 64'(bus_valid_o), 64'd1);
        check("t4_addr_held", bus_addr_o, held_addr);
        step();
        check("t4_addr_held2", bus_addr_o, held_addr);
        bus_ready_i = 1'b1;
        wait_pops(1, "t4_timeout");
        check("t4_stale_hs", hs_q[0], held_addr);
        check("t4_target_hs", hs_q[1], 64'h8000_0200);
        check("t4_pc", pop_pc[0], 64'h8000_0200);
        check("t4_inst", 64'(pop_inst[0]), 64'hDA5A_585A);

        // 5: access fault on one entry, fetch continues sequentially
        fault_addr = 64'h8000_0008;
        apply_reset();
        wait_pops(4, "t5_timeout");
        check("t5_fault1", 64'(pop_fault[1]), 64'd0);
        check("t5_pc2", pop_pc[2], 64'h8000_0008);
        check("t5_fault2", 64'(pop_fault[2]), 64'd1);
        check("t5_pc3", pop_pc[3], 64'h8000_000C);
        check("t5_fault3", 64'(pop_fault[3]), 64'd0);
        fault_addr = 64'h1;

        // 7: fetch pc wraps at the top of the address space
        jb_en_i   = 1'b1;
        jb_addr_i = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        jb_en_i = 1'b0;
        clear_logs();
        wait_pops(2, "t7_timeout");
        check("t7_pc0", pop_pc[0], 64'hFFFF_FFFF_FFFF_FFFC);
        check("t7_inst0", 64'(pop_inst[0]), 64'hA5A5_A5A6);
        check("t7_pc1", pop_pc[1], 64'h0);
        check("t7_inst1", 64'(pop_inst[1]), 64'h5A5A_5A5A);

        // 6: asynchronous reset in the middle of WAIT
        lat     = 3;
        hs_base = hs_q.size();
        for (int i = 0; i < 50 && hs_q.size() == hs_base; i++) step();
        check("t6_req_seen", 64'(hs_q.size() > hs_base), 64'd1);
        rst = 1'b0;
        #1;
        check("t6_bus_valid", 64'(bus_valid_o), 64'd0);
        check("t6_out_valid", 64'(out_valid_o), 64'd0);
        check("t6_flush", 64'(flush_o), 64'd0);
        lat = 1;
        repeat (2) step();
        clear_logs();
        rst = 1'b1;
        wait_pops(1, "t6_timeout");
        check("t6_pc", pop_pc[0], 64'h8000_0000);
        check("t6_inst", 64'(pop_inst[0]), 64'hDA5A_5A5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
